// File: rtl/instr_mem_fetch.sv
// Writable instruction memory with an init-fill engine, a program-load port
// and a one-cycle-latency valid/ready fetch port that reports misaligned and
// out-of-range PCs as fault codes.
module instr_mem_fetch #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 32,
  parameter logic [31:0] INIT_WORD   = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_done,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_wdata,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [1:0]        rsp_fault,
  input  logic              flush
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  // One extra bit so the byte capacity is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] BYTE_CAP = (ADDR_W+1)'(4 * DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             init_done_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_instr_q;
  logic [1:0]       rsp_fault_q;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             accept;
  logic             prog_in_range;
  logic             req_in_range;
  logic [IDX_W-1:0] prog_idx;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       fault_d;
  logic [31:0]      instr_d;

  assign prog_in_range = {1'b0, prog_addr} < BYTE_CAP;
  assign req_in_range  = {1'b0, req_pc} < BYTE_CAP;
  assign prog_idx      = prog_addr[IDX_W+1:2];
  assign req_idx       = req_pc[IDX_W+1:2];

  assign req_ready = (state_q == ST_RUN) && !prog_we && !flush &&
                     (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    fault_d = FAULT_OK;
    instr_d = INIT_WORD;
    if (req_pc[1:0] != 2'b00) begin
      fault_d = FAULT_ALIGN;
    end else if (!req_in_range) begin
      fault_d = FAULT_RANGE;
    end else begin
      instr_d = mem_q[req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= INIT_WORD;
      rsp_fault_q <= FAULT_OK;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase

      if (flush) begin
        rsp_valid_q <= 1'b0;
      end else if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_instr_q <= instr_d;
        rsp_fault_q <= fault_d;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Storage is not cleared by reset itself; the init engine refills it afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        mem_q[cnt_q] <= INIT_WORD;
      end else if (prog_we && prog_in_range) begin
        mem_q[prog_idx] <= prog_wdata;
      end
    end
  end

  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: a fetch-vector table plus hand-written
// sequences for init timing, writes, backpressure, flush and mid-stall reset.
module tb_instr_mem_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        init_done;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault;
  logic        flush;

  int checks = 0;
  int errors = 0;

  instr_mem_fetch #(
    .ADDR_W      (32),
    .DEPTH_WORDS (32),
    .INIT_WORD   (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_instr  (rsp_instr),
    .rsp_fault  (rsp_fault),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } fetch_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int n;
    logic ready_seen;
    n = 0;
    ready_seen = 1'b0;
    while (!init_done && n < 100) begin
      if (req_ready) ready_seen = 1'b1;
      step();
      n++;
    end
    chk({name, "_cycles"}, n, 32);
    chk({name, "_ready_low"}, {31'd0, ready_seen}, 32'd0);
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    prog_we    = 1'b1;
    prog_addr  = addr;
    prog_wdata = data;
    #1;
    chk("write_ready_low", {31'd0, req_ready}, 32'd0);
    step();
    prog_we = 1'b0;
  endtask

  fetch_vec_t vecs[9];

  initial begin
    vecs[0] = '{pc: 32'h0000_0002, instr: NOP,           fault: 2'b01};
    vecs[1] = '{pc: 32'h0000_0080, instr: NOP,           fault: 2'b10};
    vecs[2] = '{pc: 32'h0000_007C, instr: 32'h1234_5678, fault: 2'b00};
    vecs[3] = '{pc: 32'h0000_0000, instr: 32'h0094_0333, fault: 2'b00};
    vecs[4] = '{pc: 32'h0000_0083, instr: NOP,           fault: 2'b01};
    vecs[5] = '{pc: 32'h1000_0000, instr: NOP,           fault: 2'b10};
    vecs[6] = '{pc: 32'h0000_0004, instr: 32'h8001_00b3, fault: 2'b00};
    vecs[7] = '{pc: 32'h0000_0008, instr: NOP,           fault: 2'b00};
    vecs[8] = '{pc: 32'hFFFF_FFFC, instr: NOP,           fault: 2'b10};

    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    req_valid = 1'b1; req_pc = '0; rsp_ready = 1'b1; flush = 1'b0;
    step(); step(); step();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_instr", rsp_instr, NOP);
    chk("rst_rsp_fault", {30'd0, rsp_fault}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    reset = 1'b0;
    wait_init("init");
    chk("init_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // First fetch after init sees the NOP fill
    req_pc = 32'h0; req_valid = 1'b1; #1;
    chk("first_ready", {31'd0, req_ready}, 32'd1);
    step();
    chk("first_valid", {31'd0, rsp_valid}, 32'd1);
    chk("first_instr", rsp_instr, NOP);
    chk("first_fault", {30'd0, rsp_fault}, 32'd0);
    req_valid = 1'b0;
    step();
    chk("pop_valid", {31'd0, rsp_valid}, 32'd0);

    req_valid = 1'b1;
    write_word(32'h0000_0000, 32'h0094_0333);
    write_word(32'h0000_0004, 32'h8001_00b3);
    write_word(32'h0000_007E, 32'h1234_5678);
    write_word(32'h0000_0080, 32'hDEAD_BEEF);
    write_word(32'h1000_0000, 32'hCAFE_F00D);
    req_valid = 1'b0;
    chk("write_no_rsp", {31'd0, rsp_valid}, 32'd0);

    req_valid = 1'b1; req_pc = 32'h0;
    step();
    chk("b2b0_instr", rsp_instr, 32'h0094_0333);
    req_pc = 32'h4; #1;
    chk("b2b1_ready", {31'd0, req_ready}, 32'd1);
    step();
    chk("b2b1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b1_instr", rsp_instr, 32'h8001_00b3);

    for (int i = 0; i < 9; i++) begin
      req_pc = vecs[i].pc; #1;
      chk($sformatf("vec%0d_ready", i), {31'd0, req_ready}, 32'd1);
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("vec%0d_instr", i), rsp_instr, vecs[i].instr);
      chk($sformatf("vec%0d_fault", i), {30'd0, rsp_fault}, {30'd0, vecs[i].fault});
    end
    req_valid = 1'b0;
    step();
    chk("vec_drain", {31'd0, rsp_valid}, 32'd0);

    // Backpressure: response held, no acceptance while stalled
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h4;
    step();
    req_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_ready", i), {31'd0, req_ready}, 32'd0);
      step();
      chk($sformatf("stall%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_instr", i), rsp_instr, 32'h8001_00b3);
    end
    rsp_ready = 1'b1; #1;
    chk("unstall_ready", {31'd0, req_ready}, 32'd1);
    step();
    chk("unstall_valid", {31'd0, rsp_valid}, 32'd1);
    chk("unstall_instr", rsp_instr, 32'h0094_0333);

    // Flush over a held response with a pending request
    rsp_ready = 1'b0; req_pc = 32'h4;
    step();
    flush = 1'b1; #1;
    chk("flush_ready", {31'd0, req_ready}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush_valid", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1; req_pc = 32'h0;
    step();
    chk("post_flush_valid", {31'd0, rsp_valid}, 32'd1);
    chk("post_flush_instr", rsp_instr, 32'h0094_0333);

    // Reset while a response is stalled
    rsp_ready = 1'b0; req_pc = 32'h4;
    step();
    chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_instr", rsp_instr, NOP);
    chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    reset = 1'b0; rsp_ready = 1'b1; req_pc = 32'h0;
    wait_init("reinit");
    #1;
    step();
    chk("reinit_valid", {31'd0, rsp_valid}, 32'd1);
    chk("reinit_instr", rsp_instr, NOP);
    chk("reinit_fault", {30'd0, rsp_fault}, 32'd0);
    req_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised, writable instruction memory with a valid/ready fetch interface for the RISC-V core front end.
- Replaces the fixed, reset-loaded program store.
- After reset, a sequential init engine fills every word with a configurable NOP. A program-load port then writes instructions, and the fetch stage reads one little-endian 32-bit instruction per accepted request with registered one-cycle latency.
- Misaligned and out-of-range PCs return a fault code instead of garbage data.

Parameters:
- ADDR_W, 32, width of PC and program address
- DEPTH_WORDS, 32, number of 32-bit instruction words (power of two, >=2); byte capacity is 4*DEPTH_WORDS
- INIT_WORD, 32'h00000013, value written to every word during init (addi x0,x0,0)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- init_done  out  1  high once init fill has completed
- prog_we  in  1  program write strobe
- prog_addr  in  ADDR_W  byte address of word to write; bits [1:0] ignored
- prog_wdata  in  32  instruction word; byte 0 = bits [7:0]
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted this cycle when both high
- req_pc  in  ADDR_W  fetch byte address
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_instr  out  32  fetched instruction
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range
- flush  in  1  discard held or in-flight response (branch/jump redirect)

Behaviour:
- Storage: DEPTH_WORDS x 32-bit array, word index = addr[log2(DEPTH_WORDS)+1:2]. The instruction is little-endian, equivalent to {mem[pc+3],mem[pc+2],mem[pc+1],mem[pc]} byte view.
- FSM states are INIT and RUN.
- Reset (any cycle, including mid-fetch or mid-write):
  - state<=INIT, init counter<=0.
  - Outputs: init_done=0, rsp_valid=0, rsp_instr=INIT_WORD, rsp_fault=00.
- INIT:
  - Each cycle writes INIT_WORD to word[counter], then counter++.
  - After writing word DEPTH_WORDS-1, go to RUN. Init therefore takes exactly DEPTH_WORDS cycles after reset deasserts.
  - init_done rises on the first RUN cycle.
  - prog_we is ignored in INIT; req_ready=0.
- RUN, program write:
  - When prog_we=1, the word at prog_addr is written on that edge.
  - A write with prog_addr >= 4*DEPTH_WORDS is dropped silently.
  - prog_we=1 forces req_ready=0 in that cycle, so a read and a write never collide.
- RUN, fetch:
  - req_ready = RUN & !prog_we & !flush & (!rsp_valid | rsp_ready).
  - On accept (req_valid & req_ready), the next edge loads rsp_valid=1 and sets rsp_instr/rsp_fault from req_pc.
  - Latency is 1 cycle. Throughput is 1 per cycle when rsp_ready is held high.
- Fault priority:
  - misaligned (req_pc[1:0]!=0) -> 01, ahead of out-of-range (req_pc >= 4*DEPTH_WORDS) -> 10.
  - On any fault, rsp_instr=INIT_WORD.
  - The address compare uses the full ADDR_W width; PCs above capacity never alias.
- Backpressure: while rsp_valid & !rsp_ready, rsp_instr and rsp_fault are held stable and no new request is accepted.
- Response pop: on rsp_valid & rsp_ready with no accept in the same cycle, rsp_valid<=0.
- Flush: flush=1 clears rsp_valid on the next edge and blocks acceptance that cycle. Flush has priority over a pending accept and over a held response.
- Memory contents survive flush. Only reset re-initialises them.

Test Plan:
- Release reset with DEPTH_WORDS=32 -> init_done rises exactly 32 cycles later and req_ready stays low until then; fetch pc=0x0 -> rsp_valid next cycle, rsp_instr=0x00000013, rsp_fault=00.
- Program 0x00940333 @0x00 and 0x800100b3 @0x04 (req_valid high during writes) -> req_ready=0 in both write cycles; back-to-back fetch 0x00, 0x04 with rsp_ready=1 -> consecutive responses 0x00940333, 0x800100b3, one per cycle.
- Fetch pc=0x02 -> rsp_fault=01, rsp_instr=0x00000013; fetch pc=0x80 -> rsp_fault=10; fetch pc=0x7C -> fault 00; write to 0x80 -> word 0 unchanged.
- Fetch 0x04 with rsp_ready=0 for 3 cycles -> rsp_instr stays 0x800100b3 and req_ready=0 throughout; rsp_ready=1 -> pops, and a new request is accepted in the same cycle.
- Flush asserted with a valid held response and req_valid=1 -> rsp_valid=0 next cycle, no request accepted that cycle, next fetch of 0x00 still returns 0x00940333.
- Assert reset during a stalled response -> rsp_valid=0 next cycle, init repeats 32 cycles, fetch 0x00 returns 0x00000013.
